mem_arbiter: RTL and testbench

//  Shares the single-port 1024x8 data memory behind the MEM stage between two requesters:
//  the pipeline MEM port (priority) and a loader/debug port (program/data preload, dump).

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: MEM-stage port, loader/debug port and the single-port RAM side.
// Signal prefixes follow the arbiter's view (i_ into the arbiter, o_ out of it).
interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              i_mem_req;
  logic              i_mem_write;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_wdata;
  logic              o_mem_ack;
  logic [DATA_W-1:0] o_mem_rdata;
  logic              o_stall_pipe;

  logic              i_ld_req;
  logic              i_ld_write;
  logic [ADDR_W-1:0] i_ld_addr;
  logic [DATA_W-1:0] i_ld_wdata;
  logic              o_ld_ack;
  logic [DATA_W-1:0] o_ld_rdata;

  logic              o_ram_cs;
  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic [DATA_W-1:0] i_ram_rdata;

  modport slave (
    input  i_mem_req, i_mem_write, i_mem_addr, i_mem_wdata,
    output o_mem_ack, o_mem_rdata, o_stall_pipe,
    input  i_ld_req, i_ld_write, i_ld_addr, i_ld_wdata,
    output o_ld_ack, o_ld_rdata,
    output o_ram_cs, o_ram_we, o_ram_addr, o_ram_wdata,
    input  i_ram_rdata
  );

  modport master (
    output i_mem_req, i_mem_write, i_mem_addr, i_mem_wdata,
    input  o_mem_ack, o_mem_rdata, o_stall_pipe,
    output i_ld_req, i_ld_write, i_ld_addr, i_ld_wdata,
    input  o_ld_ack, o_ld_rdata,
    input  o_ram_cs, o_ram_we, o_ram_addr, o_ram_wdata,
    output i_ram_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port data RAM: pipeline MEM port has priority,
// loader port is guaranteed a win after LD_MAX_WAIT contested MEM grants in a row.
module mem_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int LD_MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam int              CNT_W   = $clog2(LD_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LD_MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_ACK
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_grant_ld;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [DATA_W-1:0] r_mem_rdata;
  logic [DATA_W-1:0] r_ld_rdata;

  logic w_any_req;
  logic w_pick_ld;
  logic w_mem_ack;

  assign w_any_req = bus.i_mem_req | bus.i_ld_req;
  // Loader wins when alone, or when MEM has already taken the contested slot LD_MAX_WAIT times.
  assign w_pick_ld = bus.i_ld_req & (~bus.i_mem_req | (r_wait_cnt == CNT_MAX));

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every signal gets its default before the case, so no path can infer a latch.
  always_comb begin
    w_next_state    = r_state;
    w_mem_ack       = 1'b0;
    bus.o_ld_ack    = 1'b0;
    bus.o_ram_cs    = 1'b0;
    bus.o_ram_we    = 1'b0;
    bus.o_ram_addr  = '0;
    bus.o_ram_wdata = '0;
    case (r_state)
      S_IDLE:    if (w_any_req) w_next_state = S_ACCESS;
      S_ACCESS: begin
        bus.o_ram_cs    = 1'b1;
        bus.o_ram_we    = r_write;
        bus.o_ram_addr  = r_addr;
        bus.o_ram_wdata = r_wdata;
        w_next_state    = S_CAPTURE;
      end
      S_CAPTURE: w_next_state = S_ACK;
      S_ACK: begin
        w_mem_ack    = ~r_grant_ld;
        bus.o_ld_ack = r_grant_ld;
        w_next_state = S_IDLE;
      end
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_ld <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_grant_ld <= w_pick_ld;
      r_write    <= w_pick_ld ? bus.i_ld_write : bus.i_mem_write;
      r_addr     <= w_pick_ld ? bus.i_ld_addr  : bus.i_mem_addr;
      r_wdata    <= w_pick_ld ? bus.i_ld_wdata : bus.i_mem_wdata;
      if (w_pick_ld)
        r_wait_cnt <= '0;
      else if (bus.i_ld_req && r_wait_cnt != CNT_MAX)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // RAM data is valid in CAPTURE, one cycle after the chip-select cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_rdata <= '0;
      r_ld_rdata  <= '0;
    end else if (r_state == S_CAPTURE && !r_write) begin
      if (r_grant_ld) r_ld_rdata  <= bus.i_ram_rdata;
      else            r_mem_rdata <= bus.i_ram_rdata;
    end
  end

  assign bus.o_mem_ack    = w_mem_ack;
  assign bus.o_stall_pipe = bus.i_mem_req & ~w_mem_ack;
  assign bus.o_mem_rdata  = r_mem_rdata;
  assign bus.o_ld_rdata   = r_ld_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single/contested transactions plus
// hand-written reset, starvation and reset-mid-access sequences against a behavioural RAM.
module tb_mem_arbiter;
  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 8;
  localparam int LD_MAX_WAIT = 4;
  localparam int NVEC        = 9;

  typedef struct {
    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic              ld_req;
    logic              ld_wr;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wd;
    int                exp_mem_cyc;
    int                exp_ld_cyc;
    logic [DATA_W-1:0] exp_mem_rd;
    logic [DATA_W-1:0] exp_ld_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_rdata;
  vec_t              vecs [NVEC];

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LD_MAX_WAIT(LD_MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears the cycle after chip select.
  always @(posedge clk) begin
    if (bus.o_ram_cs) begin
      if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_wdata;
      ram_rdata <= ram[bus.o_ram_addr];
    end
  end
  assign bus.i_ram_rdata = ram_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mr, input logic mw, input logic [ADDR_W-1:0] ma,
                              input logic [DATA_W-1:0] md, input logic lr, input logic lw,
                              input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                              input int emc, input int elc,
                              input logic [DATA_W-1:0] emr, input logic [DATA_W-1:0] elr);
    vec_t v;
    v.mem_req = mr; v.mem_wr = mw; v.mem_addr = ma; v.mem_wd = md;
    v.ld_req  = lr; v.ld_wr  = lw; v.ld_addr  = la; v.ld_wd  = ld;
    v.exp_mem_cyc = emc; v.exp_ld_cyc = elc;
    v.exp_mem_rd  = emr; v.exp_ld_rd  = elr;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of an IDLE cycle (cycle 0); returns at the start of the next IDLE.
  task automatic run_vec(input string tag, input vec_t v);
    int                mem_cyc  = -1;
    int                ld_cyc   = -1;
    bit                mem_done = !v.mem_req;
    bit                ld_done  = !v.ld_req;
    logic              win_wr   = v.mem_req ? v.mem_wr   : v.ld_wr;
    logic [ADDR_W-1:0] win_addr = v.mem_req ? v.mem_addr : v.ld_addr;
    logic [DATA_W-1:0] win_wd   = v.mem_req ? v.mem_wd   : v.ld_wd;
    bus.i_mem_req = v.mem_req; bus.i_mem_write = v.mem_wr;
    bus.i_mem_addr = v.mem_addr; bus.i_mem_wdata = v.mem_wd;
    bus.i_ld_req = v.ld_req; bus.i_ld_write = v.ld_wr;
    bus.i_ld_addr = v.ld_addr; bus.i_ld_wdata = v.ld_wd;
    for (int c = 0; c < 40 && !(mem_done && ld_done); c++) begin
      @(negedge clk);
      if (c == 0) begin
        check({tag, " stall_t0"}, bus.o_stall_pipe, v.mem_req);
        check({tag, " cs_t0"}, bus.o_ram_cs, 1'b0);
      end
      if (c == 1) begin
        check({tag, " cs_t1"}, bus.o_ram_cs, 1'b1);
        check({tag, " we_t1"}, bus.o_ram_we, win_wr);
        check({tag, " addr_t1"}, bus.o_ram_addr, win_addr);
        if (win_wr) check({tag, " wdata_t1"}, bus.o_ram_wdata, win_wd);
      end
      if (bus.o_mem_ack) begin
        mem_cyc  = c;
        mem_done = 1'b1;
        check({tag, " stall_at_ack"}, bus.o_stall_pipe, 1'b0);
      end
      if (bus.o_ld_ack) begin
        ld_cyc  = c;
        ld_done = 1'b1;
      end
      tick();
      if (mem_done) bus.i_mem_req = 1'b0;
      if (ld_done)  bus.i_ld_req  = 1'b0;
    end
    check({tag, " done"}, {mem_done, ld_done}, 2'b11);
    check({tag, " mem_ack_cyc"}, mem_cyc, v.exp_mem_cyc);
    check({tag, " ld_ack_cyc"}, ld_cyc, v.exp_ld_cyc);
    check({tag, " mem_rdata"}, bus.o_mem_rdata, v.exp_mem_rd);
    check({tag, " ld_rdata"}, bus.o_ld_rdata, v.exp_ld_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_m [5] = '{3, 7, 11, 15, 23};
    int mem_acks [$];
    int ld_acks  [$];
    int mem_left;
    bit ld_seen;

    //          mem: req wr addr     wd     ld: req wr addr     wd     mcyc lcyc mrd    lrd
    vecs[0] = mk(1, 1, 10'h001, 8'h07,   0, 0, 10'h000, 8'h00,  3, -1, 8'h00, 8'h00);
    vecs[1] = mk(1, 0, 10'h001, 8'h00,   0, 0, 10'h000, 8'h00,  3, -1, 8'h07, 8'h00);
    vecs[2] = mk(0, 0, 10'h000, 8'h00,   1, 1, 10'h3FF, 8'hA5, -1,  3, 8'h07, 8'h00);
    vecs[3] = mk(1, 0, 10'h3FF, 8'h00,   0, 0, 10'h000, 8'h00,  3, -1, 8'hA5, 8'h00);
    vecs[4] = mk(1, 1, 10'h005, 8'h3C,   1, 0, 10'h001, 8'h00,  3,  7, 8'hA5, 8'h07);
    vecs[5] = mk(1, 0, 10'h005, 8'h00,   1, 0, 10'h3FF, 8'h00,  3,  7, 8'h3C, 8'hA5);
    vecs[6] = mk(0, 0, 10'h000, 8'h00,   1, 0, 10'h005, 8'h00, -1,  3, 8'h3C, 8'h3C);
    vecs[7] = mk(1, 1, 10'h200, 8'h11,   1, 1, 10'h201, 8'h22,  3,  7, 8'h3C, 8'h3C);
    vecs[8] = mk(1, 0, 10'h201, 8'h00,   1, 0, 10'h200, 8'h00,  3,  7, 8'h22, 8'h11);

    // Reset held with both requests high: nothing may reach the RAM or the acks.
    rst_n = 1'b0;
    bus.i_mem_req = 1'b1; bus.i_mem_write = 1'b0; bus.i_mem_addr = 10'h001; bus.i_mem_wdata = 8'h00;
    bus.i_ld_req  = 1'b1; bus.i_ld_write  = 1'b1; bus.i_ld_addr  = 10'h002; bus.i_ld_wdata  = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      check("reset ram_cs", bus.o_ram_cs, 1'b0);
      check("reset ram_we", bus.o_ram_we, 1'b0);
      check("reset acks", {bus.o_mem_ack, bus.o_ld_ack}, 2'b00);
      check("reset rdata", {bus.o_mem_rdata, bus.o_ld_rdata}, 16'h0000);
    end
    tick();
    bus.i_mem_req = 1'b0;
    bus.i_ld_req  = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Loader held while MEM re-requests every IDLE: four MEM wins, then the loader.
    bus.i_mem_req = 1'b1; bus.i_mem_write = 1'b0; bus.i_mem_addr = 10'h005;
    bus.i_ld_req  = 1'b1; bus.i_ld_write  = 1'b0; bus.i_ld_addr  = 10'h201;
    mem_left = 5;
    ld_seen  = 1'b0;
    for (int c = 0; c < 40 && !(mem_left == 0 && ld_seen); c++) begin
      @(negedge clk);
      if (c == 17) check("starve stall_while_ld", bus.o_stall_pipe, 1'b1);
      if (bus.o_mem_ack) begin
        mem_acks.push_back(c);
        mem_left--;
      end
      if (bus.o_ld_ack) begin
        ld_acks.push_back(c);
        ld_seen = 1'b1;
      end
      tick();
      if (ld_seen)       bus.i_ld_req  = 1'b0;
      if (mem_left == 0) bus.i_mem_req = 1'b0;
    end
    check("starve mem_ack_count", mem_acks.size(), 5);
    check("starve ld_ack_count", ld_acks.size(), 1);
    for (int i = 0; i < 5; i++)
      check($sformatf("starve mem_ack%0d_cyc", i), (i < mem_acks.size()) ? mem_acks[i] : -1, exp_m[i]);
    check("starve ld_ack_cyc", (ld_acks.size() > 0) ? ld_acks[0] : -1, 19);
    check("starve mem_rdata", bus.o_mem_rdata, 8'h3C);
    check("starve ld_rdata", bus.o_ld_rdata, 8'h22);

    // Counter must be back at zero: a contested request goes to MEM first again.
    run_vec("post_starve", mk(1, 0, 10'h001, 8'h00, 1, 0, 10'h3FF, 8'h00, 3, 7, 8'h07, 8'hA5));

    // Reset pulsed during CAPTURE of a MEM read aborts it.
    bus.i_mem_req = 1'b1; bus.i_mem_write = 1'b0; bus.i_mem_addr = 10'h005;
    @(negedge clk);
    @(negedge clk);
    check("abort cs_access", bus.o_ram_cs, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort cs_in_reset", bus.o_ram_cs, 1'b0);
    check("abort mem_rdata", bus.o_mem_rdata, 8'h00);
    check("abort ld_rdata", bus.o_ld_rdata, 8'h00);
    check("abort mem_ack", bus.o_mem_ack, 1'b0);
    tick();
    bus.i_mem_req = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("abort quiet%0d", c), {bus.o_mem_ack, bus.o_ld_ack, bus.o_ram_cs}, 3'b000);
    end
    tick();
    run_vec("reissue", mk(1, 0, 10'h005, 8'h00, 0, 0, 10'h000, 8'h00, 3, -1, 8'h3C, 8'h00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
